// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, with signs handled in PREP and FIX.
module hilo_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            divzero_o,
    output logic [XLEN-1:0] high_o,
    output logic [XLEN-1:0] low_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t              state;
    logic                is_div;
    logic                is_signed;
    logic                neg_res;
    logic                neg_rem;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;

    logic [XLEN-1:0]     abs_a;
    logic [XLEN-1:0]     abs_b;
    logic [XLEN:0]       add_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;

    assign abs_a = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign abs_b = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

    // Multiply: low half of acc holds the remaining multiplier bits, high half the partial sum.
    assign add_sum = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q})
                            : {1'b0, acc[2*XLEN-1:XLEN]};

    // Divide: high half is the running remainder, low half shifts dividend out / quotient in.
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_trial = div_shift - {1'b0, b_q};

    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            divzero_o <= 1'b0;
            high_o    <= '0;
            low_o     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            3'b100: begin
                                high_o    <= a_i;
                                divzero_o <= 1'b0;
                            end
                            3'b101: begin
                                low_o     <= a_i;
                                divzero_o <= 1'b0;
                            end
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                if (op_i[1] && (b_i == '0)) begin
                                    // Divide by zero completes at once and leaves HI/LO alone.
                                    divzero_o <= 1'b1;
                                    done_o    <= 1'b1;
                                end else begin
                                    a_q       <= a_i;
                                    b_q       <= b_i;
                                    is_div    <= op_i[1];
                                    is_signed <= ~op_i[0];
                                    busy_o    <= 1'b1;
                                    divzero_o <= 1'b0;
                                    state     <= PREP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                PREP: begin
                    b_q     <= abs_b;
                    acc     <= {{XLEN{1'b0}}, abs_a};
                    neg_res <= is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_rem <= is_signed & a_q[XLEN-1];
                    cnt     <= '0;
                    state   <= ITER;
                end
                ITER: begin
                    if (is_div) begin
                        if (div_trial[XLEN])
                            acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        else
                            acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                    end else begin
                        acc <= {add_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        high_o <= rem_fix;
                        low_o  <= quot_fix;
                    end else begin
                        high_o <= prod_fix[2*XLEN-1:XLEN];
                        low_o  <= prod_fix[XLEN-1:0];
                    end
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
